// File: rtl/sad_vector_engine.sv
// rtl/sad_vector_engine.sv - iterative SAD engine with running minimum tracking (optional SAD_EARLY_TERM_EN)
module sad_vector_engine #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                ClearMin,
  input  logic [16*DATA_W-1:0] WV,
  input  logic [16*DATA_W-1:0] FV,
  input  logic [31:0]         FAD,
  output logic                Busy,
  output logic                Done,
  output logic [ACC_W-1:0]    SADResult,
  output logic [ACC_W-1:0]    MinSAD,
  output logic [31:0]         MinFAD,
  output logic                NewMin,
  output logic                Pruned
);

  localparam int N     = 16 / LANES;
  localparam int SUM_W = DATA_W + 5;
  localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state_q, state_d;
  logic [16*DATA_W-1:0] wv_q, fv_q;
  logic [31:0]          fad_q;
  logic [3:0]           count_q;
  logic [ACC_W-1:0]     acc_q;

  logic [DATA_W-1:0]    elem_a, elem_b, elem_diff;
  logic [SUM_W-1:0]     lane_sum;
  logic [EXT_W-1:0]     ext_sum;
  logic [ACC_W-1:0]     sum_sat;
  logic [ACC_W-1:0]     min_eff;
  logic                 last;
  logic                 prune;
  logic                 finish;

  // Absolute differences of this cycle's lanes, summed at a width that cannot overflow
  always_comb begin
    elem_a    = '0;
    elem_b    = '0;
    elem_diff = '0;
    lane_sum  = '0;
    for (int l = 0; l < LANES; l++) begin
      elem_a    = wv_q[(int'(count_q) * LANES + l) * DATA_W +: DATA_W];
      elem_b    = fv_q[(int'(count_q) * LANES + l) * DATA_W +: DATA_W];
      elem_diff = (elem_a >= elem_b) ? (elem_a - elem_b) : (elem_b - elem_a);
      lane_sum  = lane_sum + SUM_W'(elem_diff);
    end
  end

  // Saturating accumulate, minimum reference (ClearMin applies before the compare) and finish decision
  always_comb begin
    ext_sum = EXT_W'(acc_q) + EXT_W'(lane_sum);
    sum_sat = (ext_sum > EXT_W'(ACC_MAX)) ? ACC_MAX : ext_sum[ACC_W-1:0];
    last    = (count_q == 4'(N - 1));
    min_eff = ClearMin ? ACC_MAX : MinSAD;
`ifdef SAD_EARLY_TERM_EN
    prune   = (state_q == ACCUM) && !last && (sum_sat >= min_eff);
`else
    prune   = 1'b0;
`endif
    finish  = (state_q == ACCUM) && (last || prune);
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: Start is only honoured in IDLE, so a Start while busy is dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = ACCUM;
      ACCUM:   if (last || prune) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand snapshot, accumulation, result and running-minimum registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wv_q      <= '0;
      fv_q      <= '0;
      fad_q     <= '0;
      count_q   <= '0;
      acc_q     <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      NewMin    <= 1'b0;
      Pruned    <= 1'b0;
      SADResult <= '0;
      MinSAD    <= ACC_MAX;
      MinFAD    <= '0;
    end else begin
      Done   <= 1'b0;
      NewMin <= 1'b0;
      Pruned <= 1'b0;
      if (state_q == IDLE && Start) begin
        wv_q    <= WV;
        fv_q    <= FV;
        fad_q   <= FAD;
        acc_q   <= '0;
        count_q <= '0;
        Busy    <= 1'b1;
      end
      if (state_q == ACCUM) begin
        acc_q   <= sum_sat;
        count_q <= count_q + 4'd1;
      end
      if (finish) begin
        Busy      <= 1'b0;
        Done      <= 1'b1;
        Pruned    <= prune;
        SADResult <= sum_sat;
        if (!prune && (sum_sat < min_eff)) begin
          MinSAD <= sum_sat;
          MinFAD <= fad_q;
          NewMin <= 1'b1;
        end else if (ClearMin) begin
          MinSAD <= ACC_MAX;
          MinFAD <= '0;
        end
      end else if (ClearMin) begin
        MinSAD <= ACC_MAX;
        MinFAD <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sad_vector_engine.sv
// tb/tb_sad_vector_engine.sv - scoreboard bench for sad_vector_engine (default build)
module tb_sad_vector_engine;

  logic         Clk = 1'b0;
  logic         Reset, Start, ClearMin;
  logic [511:0] WV, FV;
  logic [31:0]  FAD;
  logic         Busy, Done, NewMin, Pruned;
  logic [31:0]  SADResult, MinSAD, MinFAD;

  sad_vector_engine #(.LANES(4), .DATA_W(32), .ACC_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ClearMin(ClearMin),
    .WV(WV), .FV(FV), .FAD(FAD),
    .Busy(Busy), .Done(Done), .SADResult(SADResult),
    .MinSAD(MinSAD), .MinFAD(MinFAD), .NewMin(NewMin), .Pruned(Pruned)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          cyc;
    logic [31:0] sad;
    logic        nm;
    logic [31:0] minsad;
    logic [31:0] minfad;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] m_min;
  logic [31:0] m_fad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_sad(input logic [511:0] w, input logic [511:0] f);
    longint unsigned s = 0;
    longint unsigned a, b;
    for (int i = 0; i < 16; i++) begin
      a = w[i*32 +: 32];
      b = f[i*32 +: 32];
      s += (a >= b) ? (a - b) : (b - a);
    end
    if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
    return 32'(s);
  endfunction

  function automatic logic [511:0] fill(input logic [31:0] v);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [511:0] rand_vec(input int mode);
    logic [511:0] r;
    for (int i = 0; i < 16; i++)
      r[i*32 +: 32] = (mode == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
    return r;
  endfunction

  // Called on a falling edge; returns on the falling edge where Done is visible
  task automatic run(input logic [511:0] w, input logic [511:0] f, input logic [31:0] fad,
                     input bit clr_at_done, input bit mid_start);
    exp_t        e;
    logic [31:0] s;
    s = ref_sad(w, f);
    if (clr_at_done) begin
      m_min = '1;
      m_fad = '0;
    end
    e.nm = (s < m_min);
    if (e.nm) begin
      m_min = s;
      m_fad = fad;
    end
    e.sad    = s;
    e.minsad = m_min;
    e.minfad = m_fad;
    e.cyc    = cyc + 5;
    exp_q.push_back(e);
    WV = w; FV = f; FAD = fad; Start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clk);
      if (i == 1) begin
        Start = 1'b0;
        WV    = rand_vec(1);
        FV    = rand_vec(1);
        FAD   = $urandom;
      end
      if (mid_start) Start = (i == 2);
      ClearMin = clr_at_done && (i == 4);
      chk("busy_accum", Busy, 1);
    end
    @(negedge Clk);
    ClearMin = 1'b0;
    chk("busy_at_done", Busy, 0);
  endtask

  // Monitor: every Done pops one expectation from the scoreboard
  always @(negedge Clk) begin
    if (!Reset && Done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got Done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_cycle", cyc, mon_e.cyc);
        chk("sad_result", SADResult, mon_e.sad);
        chk("new_min", NewMin, mon_e.nm);
        chk("min_sad", MinSAD, mon_e.minsad);
        chk("min_fad", MinFAD, mon_e.minfad);
        chk("pruned", Pruned, 0);
      end
    end
    if (!Done && (NewMin || Pruned)) begin
      tests++;
      fails++;
      $display("FAIL pulse_without_done: got NewMin=%0b Pruned=%0b expected 0", NewMin, Pruned);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [511:0] w, f;

  initial begin
    Reset = 1'b1; Start = 1'b0; ClearMin = 1'b0;
    WV = '0; FV = '0; FAD = '0;
    m_min = '1; m_fad = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_sad", SADResult, 0);
    chk("rst_minsad", MinSAD, 32'hFFFF_FFFF);
    chk("rst_minfad", MinFAD, 0);
    chk("rst_newmin", NewMin, 0);
    @(negedge Clk);

    // Directed: first min, larger result, tie, saturation (back-to-back starts)
    run(fill(10), fill(7), 32'h100, 0, 0);
    for (int i = 0; i < 16; i++) begin
      w[i*32 +: 32] = i;
      f[i*32 +: 32] = 15 - i;
    end
    run(w, f, 32'h200, 0, 0);
    run(fill(10), fill(7), 32'h300, 0, 0);
    w = fill(5); f = fill(5);
    w[31:0] = 32'hFFFF_FFFF; f[31:0] = 0;
    w[63:32] = 32'hFFFF_FFFF; f[63:32] = 0;
    run(w, f, 32'h340, 0, 0);

    // Start during ACCUM must be dropped
    run(rand_vec(0), rand_vec(0), 32'h380, 0, 1);
    repeat (6) @(negedge Clk);

    // ClearMin while idle, then ClearMin coincident with Done
    ClearMin = 1'b1;
    @(negedge Clk);
    ClearMin = 1'b0;
    m_min = '1; m_fad = '0;
    chk("clr_idle_minsad", MinSAD, 32'hFFFF_FFFF);
    chk("clr_idle_minfad", MinFAD, 0);
    run(fill(10), fill(7), 32'h400, 0, 0);
    w = '0; f = '0;
    w[31:0] = 500;
    run(w, f, 32'h500, 1, 0);

    // Reset two edges into a computation aborts it
    WV = fill(9); FV = fill(1); FAD = 32'h600; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    m_min = '1; m_fad = '0;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_sad", SADResult, 0);
    chk("abort_minsad", MinSAD, 32'hFFFF_FFFF);
    chk("abort_minfad", MinFAD, 0);
    repeat (6) @(negedge Clk);

    // Randomized runs against the reference model
    for (int n = 0; n < 30; n++) begin
      run(rand_vec($urandom_range(0, 1) == 0 ? 0 : ($urandom_range(0, 3) == 0 ? 1 : 0)),
          rand_vec(0), $urandom, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    repeat (8) @(negedge Clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
